// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: branch condition codes, MEM-stage FSM
// state encoding and the default overflow trap vector.
package mips_pkg;

    localparam logic [2:0] COND_BEQ    = 3'd0;
    localparam logic [2:0] COND_BNE    = 3'd1;
    localparam logic [2:0] COND_BLT    = 3'd2;
    localparam logic [2:0] COND_BGE    = 3'd3;
    localparam logic [2:0] COND_BLEZ   = 3'd4;
    localparam logic [2:0] COND_BGTZ   = 3'd5;
    localparam logic [2:0] COND_ALWAYS = 3'd6;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } ms_state_e;

    localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition decode from ALU flags; shared with the
// EX-stage early-branch unit.
module branch_cond_eval
    import mips_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       less,
    input  logic       zero,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_BEQ:    cond_true = zero;
            COND_BNE:    cond_true = !zero;
            COND_BLT:    cond_true = less;
            COND_BGE:    cond_true = !less;
            COND_BLEZ:   cond_true = less | zero;
            COND_BGTZ:   cond_true = !less & !zero;
            COND_ALWAYS: cond_true = 1'b1;
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage control: branch resolution / PC redirect, flush and stall, data
// memory req/ack handshake with timeout, load capture. Overflow trap: OVF_TRAP_EN.
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int          ACK_TIMEOUT = 16,
    parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Branch_MEM,
    input  logic [2:0]  Condition_MEM,
    input  logic        Less_MEM,
    input  logic        Zero_MEM,
    input  logic        Overflow_MEM,
    input  logic [31:0] Branch_addr_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [31:0] WBData_MEM,
    input  logic [31:0] MemData_MEM,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        PC_redirect,
    output logic [31:0] PC_target,
    output logic        flush_out,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [31:0] Load_data,
    output logic        Load_valid,
    output logic        Bus_err,
    output logic        Exc_overflow
);

    localparam int CW = $clog2(ACK_TIMEOUT) + 1;

    ms_state_e       state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            cond_true;
    logic            in_idle;
    logic            in_wait;
    logic            taken;
    logic            ovf_trap;
    logic            access;
    logic            is_read;
    logic            capture;

    branch_cond_eval u_cond (
        .cond      (Condition_MEM),
        .less      (Less_MEM),
        .zero      (Zero_MEM),
        .cond_true (cond_true)
    );

    assign in_idle = (state_reg == MS_IDLE);
    assign in_wait = (state_reg == MS_WAIT);
    assign taken   = Branch_MEM & cond_true & in_idle;

`ifdef OVF_TRAP_EN
    assign ovf_trap = Overflow_MEM & in_idle & !Branch_MEM;
`else
    logic unused_ovf;
    assign unused_ovf = Overflow_MEM;
    assign ovf_trap   = 1'b0;
`endif

    // A trapping or branching instruction never touches memory.
    assign access  = (MemRead_MEM | MemWrite_MEM) & !Branch_MEM & !ovf_trap;
    assign is_read = MemRead_MEM & !MemWrite_MEM;

    // Gated by rst_n so a reset mid-access drops the request immediately.
    assign dmem_req   = rst_n & (in_wait | (in_idle & access));
    assign dmem_we    = dmem_req & MemWrite_MEM;
    assign dmem_addr  = WBData_MEM;
    assign dmem_wdata = MemData_MEM;
    assign stall_out  = dmem_req & !dmem_ack;
    assign capture    = dmem_req & dmem_ack & is_read;

    assign PC_redirect = rst_n & (taken | ovf_trap);
    assign flush_out   = PC_redirect;
    assign PC_target   = taken    ? Branch_addr_MEM :
                         ovf_trap ? TRAP_VECTOR     : 32'h0;

    // cnt_reg counts stalled cycles including the first (IDLE) one, so the
    // stage is held for at most ACK_TIMEOUT cycles in total.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= MS_IDLE;
            cnt_reg      <= '0;
            Load_data    <= 32'h0;
            Load_valid   <= 1'b0;
            Bus_err      <= 1'b0;
            Exc_overflow <= 1'b0;
        end else begin
            Load_valid   <= 1'b0;
            Exc_overflow <= ovf_trap;
            if (capture) begin
                Load_data  <= dmem_rdata;
                Load_valid <= 1'b1;
            end
            case (state_reg)
                MS_IDLE: begin
                    if (access && !dmem_ack) begin
                        state_reg <= MS_WAIT;
                        cnt_reg   <= CW'(1);
                    end
                end
                MS_WAIT: begin
                    if (dmem_ack) begin
                        state_reg <= MS_IDLE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CW'(ACK_TIMEOUT - 1)) begin
                        state_reg <= MS_IDLE;
                        cnt_reg   <= '0;
                        Bus_err   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= MS_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (falling-edge design;
// inputs driven and outputs sampled around the rising edge).
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Branch_MEM;
    logic [2:0]  Condition_MEM;
    logic        Less_MEM, Zero_MEM, Overflow_MEM;
    logic [31:0] Branch_addr_MEM;
    logic        MemRead_MEM, MemWrite_MEM;
    logic [31:0] WBData_MEM, MemData_MEM;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        PC_redirect;
    logic [31:0] PC_target;
    logic        flush_out, stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, Load_data;
    logic        Load_valid, Bus_err, Exc_overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.ACK_TIMEOUT(16), .TRAP_VECTOR(32'h0000_0080)) dut (
        .clk(clk), .rst_n(rst_n),
        .Branch_MEM(Branch_MEM), .Condition_MEM(Condition_MEM),
        .Less_MEM(Less_MEM), .Zero_MEM(Zero_MEM), .Overflow_MEM(Overflow_MEM),
        .Branch_addr_MEM(Branch_addr_MEM),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .WBData_MEM(WBData_MEM), .MemData_MEM(MemData_MEM),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .PC_redirect(PC_redirect), .PC_target(PC_target),
        .flush_out(flush_out), .stall_out(stall_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .Load_data(Load_data), .Load_valid(Load_valid),
        .Bus_err(Bus_err), .Exc_overflow(Exc_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        Branch_MEM = 0; Condition_MEM = 0; Less_MEM = 0; Zero_MEM = 0;
        Overflow_MEM = 0; Branch_addr_MEM = 0; MemRead_MEM = 0; MemWrite_MEM = 0;
        WBData_MEM = 0; MemData_MEM = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    // {cond, less, zero, expected taken}
    logic [5:0] br_vec [13] = '{
        {3'd0, 1'b0, 1'b1, 1'b1}, {3'd0, 1'b0, 1'b0, 1'b0},
        {3'd1, 1'b0, 1'b0, 1'b1}, {3'd1, 1'b0, 1'b1, 1'b0},
        {3'd2, 1'b1, 1'b0, 1'b1}, {3'd3, 1'b1, 1'b0, 1'b0},
        {3'd3, 1'b0, 1'b0, 1'b1}, {3'd4, 1'b0, 1'b1, 1'b1},
        {3'd4, 1'b0, 1'b0, 1'b0}, {3'd5, 1'b1, 1'b0, 1'b0},
        {3'd5, 1'b0, 1'b0, 1'b1}, {3'd6, 1'b0, 1'b0, 1'b1},
        {3'd7, 1'b1, 1'b1, 1'b0}
    };

    initial begin
        int n;
        logic [5:0] v;
        clear_inputs();
        rst_n = 0;
        #3;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_redirect", PC_redirect, 0);
        chk("rst_load_data", Load_data, 0);
        chk("rst_load_valid", Load_valid, 0);
        chk("rst_bus_err", Bus_err, 0);
        chk("rst_exc", Exc_overflow, 0);
        @(posedge clk); rst_n = 1;

        // BEQ taken for exactly one cycle, then the flushed register clears it
        @(posedge clk);
        Branch_MEM = 1; Condition_MEM = 0; Zero_MEM = 1; Branch_addr_MEM = 32'h40;
        MemRead_MEM = 1;
        #1;
        chk("beq_redirect", PC_redirect, 1);
        chk("beq_target", PC_target, 32'h40);
        chk("beq_flush", flush_out, 1);
        chk("beq_no_req", dmem_req, 0);
        @(negedge clk); #1;
        clear_inputs();
        #1;
        chk("beq_redirect_gone", PC_redirect, 0);
        chk("beq_flush_gone", flush_out, 0);
        $display("txn beq_taken redirect one cycle");

        // condition decode table
        for (int i = 0; i < 13; i++) begin
            v = br_vec[i];
            @(posedge clk);
            Branch_MEM = 1; Condition_MEM = v[5:3]; Less_MEM = v[2]; Zero_MEM = v[1];
            Branch_addr_MEM = 32'h1000 + 32'(i * 4);
            MemWrite_MEM = 1;
            #1;
            chk($sformatf("cond%0d_redirect", i), PC_redirect, v[0]);
            chk($sformatf("cond%0d_target", i), PC_target, v[0] ? 32'h1000 + 32'(i * 4) : 32'h0);
            chk($sformatf("cond%0d_req", i), dmem_req, 0);
            $display("txn branch cond=%0d less=%0d zero=%0d redirect=%0d", v[5:3], v[2], v[1], PC_redirect);
            @(negedge clk); #1;
            clear_inputs();
        end

        // load acked after 3 stalled cycles
        @(posedge clk);
        MemRead_MEM = 1; WBData_MEM = 32'h200;
        #1;
        chk("ld_req", dmem_req, 1);
        chk("ld_we", dmem_we, 0);
        chk("ld_addr", dmem_addr, 32'h200);
        chk("ld_stall0", stall_out, 1);
        @(negedge clk);
        @(posedge clk); #1; chk("ld_stall1", stall_out, 1);
        @(negedge clk);
        @(posedge clk); #1; chk("ld_stall2", stall_out, 1);
        @(negedge clk);
        @(posedge clk);
        dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_stall_release", stall_out, 0);
        chk("ld_req_ack", dmem_req, 1);
        @(negedge clk); #1;
        chk("ld_valid", Load_valid, 1);
        chk("ld_data", Load_data, 32'hDEADBEEF);
        clear_inputs();
        @(negedge clk); #1;
        chk("ld_valid_pulse", Load_valid, 0);
        chk("ld_idle_req", dmem_req, 0);
        $display("txn load addr=200 data=%h", Load_data);

        // store with zero-wait ack
        @(posedge clk);
        MemWrite_MEM = 1; WBData_MEM = 32'h100; MemData_MEM = 32'h5; dmem_ack = 1;
        #1;
        chk("st_req", dmem_req, 1);
        chk("st_we", dmem_we, 1);
        chk("st_addr", dmem_addr, 32'h100);
        chk("st_wdata", dmem_wdata, 32'h5);
        chk("st_stall", stall_out, 0);
        @(negedge clk); #1;
        chk("st_no_load_valid", Load_valid, 0);
        clear_inputs();
        $display("txn store addr=100 data=5");

        // timeout: pipeline advances once the abort has registered
        @(posedge clk);
        MemRead_MEM = 1; WBData_MEM = 32'h300;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(posedge clk);
            #1;
            if (stall_out) n++;
            @(negedge clk); #1;
            if (Bus_err) begin
                MemRead_MEM = 0;
                break;
            end
        end
        chk("to_stall_cycles", n, 16);
        chk("to_bus_err", Bus_err, 1);
        chk("to_no_load_valid", Load_valid, 0);
        #1;
        chk("to_stall_released", stall_out, 0);
        $display("txn timeout stall_cycles=%0d bus_err=%0d", n, Bus_err);

        // later load completes normally; Bus_err sticks
        @(posedge clk);
        MemRead_MEM = 1; WBData_MEM = 32'h304; dmem_ack = 1; dmem_rdata = 32'h1234_5678;
        #1;
        chk("ld2_stall", stall_out, 0);
        @(negedge clk); #1;
        chk("ld2_valid", Load_valid, 1);
        chk("ld2_data", Load_data, 32'h1234_5678);
        chk("ld2_bus_err_sticky", Bus_err, 1);
        clear_inputs();
        $display("txn load addr=304 data=%h", Load_data);

        // late ack without request is ignored
        @(posedge clk);
        dmem_ack = 1; dmem_rdata = 32'hAAAA_AAAA;
        #1;
        chk("late_ack_req", dmem_req, 0);
        @(negedge clk); #1;
        chk("late_ack_valid", Load_valid, 0);
        chk("late_ack_data", Load_data, 32'h1234_5678);
        clear_inputs();
        $display("txn late_ack ignored");

        // reset asserted mid-WAIT
        @(posedge clk);
        MemRead_MEM = 1; WBData_MEM = 32'h400;
        @(negedge clk);
        @(posedge clk); #1;
        chk("rw_stall_before", stall_out, 1);
        rst_n = 0;
        #1;
        chk("rw_req", dmem_req, 0);
        chk("rw_stall", stall_out, 0);
        chk("rw_bus_err", Bus_err, 0);
        chk("rw_load_data", Load_data, 0);
        chk("rw_load_valid", Load_valid, 0);
        clear_inputs();
        @(posedge clk); rst_n = 1;
        @(negedge clk); #1;
        chk("rw_idle_after", dmem_req, 0);
        $display("txn reset_mid_wait");

        // overflow handling
        @(posedge clk);
        Overflow_MEM = 1; MemRead_MEM = 1;
        #1;
`ifdef OVF_TRAP_EN
        chk("ovf_redirect", PC_redirect, 1);
        chk("ovf_target", PC_target, 32'h80);
        chk("ovf_flush", flush_out, 1);
        chk("ovf_no_req", dmem_req, 0);
        @(negedge clk); #1;
        chk("ovf_exc", Exc_overflow, 1);
        clear_inputs();
        @(negedge clk); #1;
        chk("ovf_exc_pulse", Exc_overflow, 0);
        @(posedge clk);
        Overflow_MEM = 1; Branch_MEM = 1; Condition_MEM = 3'd6; Branch_addr_MEM = 32'h500;
        #1;
        chk("ovf_branch_wins", PC_target, 32'h500);
        @(negedge clk); #1;
        chk("ovf_branch_no_exc", Exc_overflow, 0);
`else
        chk("ovf_ignored_redirect", PC_redirect, 0);
        chk("ovf_ignored_req", dmem_req, 1);
        dmem_ack = 1;
        @(negedge clk); #1;
        chk("ovf_exc_tied", Exc_overflow, 0);
`endif
        clear_inputs();
        $display("txn overflow");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
